// File: rtl/gpu_input_pkg.sv
// Shared opcode constants, decoder states and word field offsets for the triangle input queue.
package gpu_input_pkg;

    localparam logic [3:0] OP_TRI       = 4'h1;
    localparam logic [3:0] OP_FRAME_END = 4'h2;
    localparam logic [3:0] OP_CLEAR     = 4'h3;

    localparam int unsigned OP_LSB = 28;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned Y_LSB  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        VERT = 1'b1
    } dec_state_e;

endpackage

// File: rtl/tri_fifo.sv
// Synchronous FIFO with flush and a registered head-of-queue view.
// The head register is loaded with the entry that will be at the head after
// the current edge, so a push into an empty FIFO is visible one cycle later
// and the last head value is held while the FIFO is empty.
module tri_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             flush,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic [CW-1:0]    count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_next;
    logic [PW-1:0]    rd_next;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = CW'(wr_ptr - rd_ptr);

    // Qualify requests and compute the pointers after this edge.
    always_comb begin
        push_ok = push && !full && !flush;
        pop_ok  = pop && !empty && !flush;
        wr_next = wr_ptr + PW'(push_ok);
        rd_next = rd_ptr + PW'(pop_ok);
        if (flush) begin
            wr_next = '0;
            rd_next = '0;
        end
    end

    // Storage write; contents need no reset since validity lives in the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
        end
    end

    // Head register, bypassing the incoming word when it lands at the new head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_valid <= 1'b0;
            head_data  <= '0;
        end else if (wr_next != rd_next) begin
            head_valid <= 1'b1;
            if (push_ok && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
                head_data <= din;
            end else begin
                head_data <= mem[rd_next[AW-1:0]];
            end
        end else begin
            head_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/triangle_input_queue.sv
// Host protocol decoder: assembles triangles from the write port and queues
// them, with frame-end markers, for the rasteriser front end.
module triangle_input_queue
    import gpu_input_pkg::*;
#(
    parameter int unsigned COORD_W    = 16,
    parameter int unsigned TEX_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               write,
    input  logic [31:0]                        w_data,
    input  logic                               next_triangle,
    output logic                               w_ready,
    output logic                               opcode_received,
    output logic                               frame_ready,
    output logic                               data_ready,
    output logic [COORD_W-1:0]                 x1,
    output logic [COORD_W-1:0]                 y1,
    output logic [COORD_W-1:0]                 x2,
    output logic [COORD_W-1:0]                 y2,
    output logic [COORD_W-1:0]                 x3,
    output logic [COORD_W-1:0]                 y3,
    output logic [TEX_W-1:0]                   tex_num,
    output logic                               proto_error,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int unsigned ENTRY_W = 6 * COORD_W + TEX_W + 1;

    dec_state_e         state_q, state_d;
    logic [1:0]         vidx_q, vidx_d;
    logic [TEX_W-1:0]   tex_q, tex_d;
    logic [COORD_W-1:0] vx_q [2];
    logic [COORD_W-1:0] vy_q [2];
    logic [COORD_W-1:0] vx_d [2];
    logic [COORD_W-1:0] vy_d [2];
    logic               opc_d;
    logic               perr_d;

    logic               accept;
    logic [OP_W-1:0]    opcode;
    logic [COORD_W-1:0] x_in;
    logic [COORD_W-1:0] y_in;
    logic               push;
    logic               flush;
    logic [ENTRY_W-1:0] entry;

    logic               fifo_full;
    logic               head_valid;
    logic [ENTRY_W-1:0] head_data;
    logic               head_marker;
    logic               unused_w_data;

    assign accept        = write && w_ready;
    assign opcode        = w_data[OP_LSB +: OP_W];
    assign x_in          = w_data[0 +: COORD_W];
    assign y_in          = w_data[Y_LSB +: COORD_W];
    assign unused_w_data = ^w_data;

    // Decoder next-state, staging updates and FIFO requests.
    always_comb begin
        state_d = state_q;
        vidx_d  = vidx_q;
        tex_d   = tex_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        opc_d   = 1'b0;
        perr_d  = proto_error;
        push    = 1'b0;
        flush   = 1'b0;
        entry   = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (opcode)
                        OP_TRI: begin
                            tex_d   = w_data[TEX_W-1:0];
                            vidx_d  = 2'd0;
                            state_d = VERT;
                            opc_d   = 1'b1;
                        end
                        OP_FRAME_END: begin
                            // Markers carry zero payload; only the LSB flag is set.
                            entry = ENTRY_W'(1);
                            push  = 1'b1;
                            opc_d = 1'b1;
                        end
                        OP_CLEAR: begin
                            flush  = 1'b1;
                            perr_d = 1'b0;
                            opc_d  = 1'b1;
                        end
                        default: begin
                            perr_d = 1'b1;
                        end
                    endcase
                end
            end
            VERT: begin
                if (accept) begin
                    if (vidx_q == 2'd2) begin
                        entry   = {tex_q, vx_q[0], vy_q[0], vx_q[1], vy_q[1], x_in, y_in, 1'b0};
                        push    = 1'b1;
                        vidx_d  = 2'd0;
                        state_d = IDLE;
                    end else begin
                        vx_d[vidx_q[0]] = x_in;
                        vy_d[vidx_q[0]] = y_in;
                        vidx_d          = vidx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Decoder state, staging registers and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            vidx_q          <= 2'd0;
            tex_q           <= '0;
            vx_q            <= '{default: '0};
            vy_q            <= '{default: '0};
            opcode_received <= 1'b0;
            proto_error     <= 1'b0;
        end else begin
            state_q         <= state_d;
            vidx_q          <= vidx_d;
            tex_q           <= tex_d;
            vx_q            <= vx_d;
            vy_q            <= vy_d;
            opcode_received <= opc_d;
            proto_error     <= perr_d;
        end
    end

    tri_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push       (push),
        .din        (entry),
        .pop        (next_triangle),
        .flush      (flush),
        .head_valid (head_valid),
        .head_data  (head_data),
        .full       (fifo_full),
        .count      (fifo_count)
    );

    assign w_ready = !fifo_full;
    assign {tex_num, x1, y1, x2, y2, x3, y3, head_marker} = head_data;
    assign data_ready  = head_valid && !head_marker;
    assign frame_ready = head_valid && head_marker;

endmodule

// File: tb/tb_triangle_input_queue.sv
// Randomised and directed bench for triangle_input_queue against a queue-based model.
module tb_triangle_input_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic        marker;
        logic [7:0]  tex;
        logic [15:0] x1, y1, x2, y2, x3, y3;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        write = 1'b0;
    logic [31:0] w_data = '0;
    logic        next_triangle = 1'b0;
    logic        w_ready, opcode_received, frame_ready, data_ready, proto_error;
    logic [15:0] x1, y1, x2, y2, x3, y3;
    logic [7:0]  tex_num;
    logic [2:0]  fifo_count;

    triangle_input_queue #(.COORD_W(16), .TEX_W(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .write(write), .w_data(w_data),
        .next_triangle(next_triangle), .w_ready(w_ready),
        .opcode_received(opcode_received), .frame_ready(frame_ready),
        .data_ready(data_ready), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .x3(x3), .y3(y3), .tex_num(tex_num), .proto_error(proto_error),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state
    ent_t        q[$];
    ent_t        mhead;
    bit          m_vert;
    int          m_vidx;
    logic [7:0]  m_tex;
    logic [15:0] m_vx[3];
    logic [15:0] m_vy[3];
    bit          m_perr;
    bit          m_opc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mhead  = '0;
        m_vert = 0;
        m_vidx = 0;
        m_tex  = '0;
        m_perr = 0;
        m_opc  = 0;
    endtask

    // Apply one edge's worth of protocol rules to the model.
    task automatic model_edge(input bit wr, input logic [31:0] d, input bit pop);
        bit   accept, clr, do_push;
        ent_t e;
        accept  = wr && (q.size() < DEPTH);
        clr     = 0;
        do_push = 0;
        e       = '0;
        m_opc   = 0;
        if (accept && !m_vert) begin
            case (d[31:28])
                4'h1: begin m_tex = d[7:0]; m_vert = 1; m_vidx = 0; m_opc = 1; end
                4'h2: begin e.marker = 1; do_push = 1; m_opc = 1; end
                4'h3: begin clr = 1; m_perr = 0; m_opc = 1; end
                default: m_perr = 1;
            endcase
        end else if (accept) begin
            m_vx[m_vidx] = d[15:0];
            m_vy[m_vidx] = d[31:16];
            if (m_vidx == 2) begin
                e = '{marker: 1'b0, tex: m_tex, x1: m_vx[0], y1: m_vy[0],
                      x2: m_vx[1], y2: m_vy[1], x3: m_vx[2], y3: m_vy[2]};
                do_push = 1;
                m_vert  = 0;
                m_vidx  = 0;
            end else begin
                m_vidx++;
            end
        end
        if (clr) begin
            q.delete();
        end else begin
            if (pop && q.size() > 0) void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
        if (q.size() > 0) mhead = q[0];
    endtask

    // Compare every observable output against the model.
    task automatic compare();
        chk("w_ready", 32'(w_ready), 32'(q.size() < DEPTH));
        chk("opcode_received", 32'(opcode_received), 32'(m_opc));
        chk("proto_error", 32'(proto_error), 32'(m_perr));
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        chk("data_ready", 32'(data_ready), 32'(q.size() > 0 && !q[0].marker));
        chk("frame_ready", 32'(frame_ready), 32'(q.size() > 0 && q[0].marker));
        chk("tex_num", 32'(tex_num), 32'(mhead.tex));
        chk("xy1", {x1, y1}, {mhead.x1, mhead.y1});
        chk("xy2", {x2, y2}, {mhead.x2, mhead.y2});
        chk("xy3", {x3, y3}, {mhead.x3, mhead.y3});
    endtask

    task automatic step(input bit wr, input logic [31:0] d, input bit pop);
        write         = wr;
        w_data        = d;
        next_triangle = pop;
        @(posedge clk);
        model_edge(wr, d, pop);
        #1;
        compare();
        @(negedge clk);
        write         = 0;
        next_triangle = 0;
    endtask

    task automatic send_tri(input logic [7:0] tex, input logic [15:0] base, input bit pop_last);
        step(1, {4'h1, 20'h0, tex}, 0);
        step(1, {base + 16'd1, base}, 0);
        step(1, {base + 16'd3, base + 16'd2}, 0);
        step(1, {base + 16'd5, base + 16'd4}, pop_last);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0;
        #1;
        model_reset();
        compare();
        @(negedge clk);
        reset = 1;
    endtask

    initial begin
        model_reset();
        #1;
        compare();
        chk("reset_w_ready", 32'(w_ready), 32'd1);
        @(negedge clk);
        reset = 1;

        // First triangle and its literal head values
        step(1, 32'h1000_0007, 0);
        chk("lit_opc_pulse", 32'(opcode_received), 32'd1);
        step(1, 32'h0002_0001, 0);
        chk("lit_opc_once", 32'(opcode_received), 32'd0);
        step(1, 32'h0004_0003, 0);
        step(1, 32'h0006_0005, 0);
        chk("lit_data_ready", 32'(data_ready), 32'd1);
        chk("lit_tex7", 32'(tex_num), 32'd7);
        chk("lit_x", {x1, x2, x3}, {16'd1, 16'd3, 16'd5});
        chk("lit_y", {y1, y2, y3}, {16'd2, 16'd4, 16'd6});
        chk("lit_count1", 32'(fifo_count), 32'd1);

        // Frame-end marker behind the triangle
        step(1, 32'h2000_0000, 0);
        step(0, 0, 1);
        chk("lit_frame_ready", 32'(frame_ready), 32'd1);
        chk("lit_data_ready0", 32'(data_ready), 32'd0);
        step(0, 0, 1);
        chk("lit_count0", 32'(fifo_count), 32'd0);

        // Fill to depth, then pop in order with a simultaneous push
        for (int i = 1; i <= DEPTH; i++) send_tri(8'(i), 16'(i * 16), 0);
        chk("lit_full_w_ready", 32'(w_ready), 32'd0);
        chk("lit_full_count", 32'(fifo_count), 32'd4);
        chk("lit_head_tex1", 32'(tex_num), 32'd1);
        step(0, 0, 1);
        chk("lit_head_tex2", 32'(tex_num), 32'd2);
        send_tri(8'd5, 16'h100, 1);
        chk("lit_pushpop_count", 32'(fifo_count), 32'd3);
        chk("lit_head_tex3", 32'(tex_num), 32'd3);
        step(0, 0, 1);
        chk("lit_head_tex4", 32'(tex_num), 32'd4);
        step(0, 0, 1);
        chk("lit_head_tex5", 32'(tex_num), 32'd5);
        step(0, 0, 1);

        // Unknown opcode then CLEAR
        send_tri(8'd8, 16'h200, 0);
        step(1, 32'h5000_0000, 0);
        chk("lit_perr1", 32'(proto_error), 32'd1);
        chk("lit_perr_no_opc", 32'(opcode_received), 32'd0);
        chk("lit_perr_count", 32'(fifo_count), 32'd1);
        step(1, 32'h3000_0000, 1);
        chk("lit_clear_perr", 32'(proto_error), 32'd0);
        chk("lit_clear_count", 32'(fifo_count), 32'd0);
        chk("lit_clear_opc", 32'(opcode_received), 32'd1);

        // Reset in the middle of a triangle
        step(1, 32'h1000_0003, 0);
        step(1, 32'h0011_0010, 0);
        step(1, 32'h0013_0012, 0);
        do_reset();
        send_tri(8'd9, 16'h300, 0);
        chk("lit_rst_count", 32'(fifo_count), 32'd1);
        chk("lit_rst_tex9", 32'(tex_num), 32'd9);
        chk("lit_rst_x1", 32'(x1), 32'h300);

        // Pops on an empty FIFO, then a single push
        step(0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        chk("lit_empty_count", 32'(fifo_count), 32'd0);
        chk("lit_empty_hold_tex", 32'(tex_num), 32'd9);
        send_tri(8'd10, 16'h400, 0);
        chk("lit_after_empty_count", 32'(fifo_count), 32'd1);

        // Randomised traffic in phases of varying pop pressure
        for (int ph = 0; ph < 6; ph++) begin
            int pop_pct;
            pop_pct = (ph % 3 == 0) ? 10 : ((ph % 3 == 1) ? 45 : 80);
            for (int c = 0; c < 400; c++) begin
                int          r;
                logic [3:0]  op;
                logic [31:0] d;
                r  = int'($urandom_range(0, 99));
                op = (r < 55) ? 4'h1 : (r < 80) ? 4'h2 : (r < 84) ? 4'h3 :
                     (r < 90) ? 4'(4 + $urandom_range(0, 11)) : 4'h1;
                d  = $urandom;
                d[31:28] = op;
                step($urandom_range(0, 99) < 70, d, int'($urandom_range(0, 99)) < pop_pct);
            end
            if (ph == 3) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
